// File: rtl/air_hockey_pkg.sv
// Shared types and helpers for the air hockey match timer.
// Optional warn output is enabled by GAME_TIMER_WARN_EN.
package air_hockey_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    OVER
  } state_t;

  localparam int BCD_W = 4;
  localparam int WARN_SECONDS = 10;

  function automatic logic [2*BCD_W-1:0] to_bcd(
    input int unsigned v
  );
    logic [2*BCD_W-1:0] r;
    r[2*BCD_W-1:BCD_W] = BCD_W'(v / 10);
    r[BCD_W-1:0] = BCD_W'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down counter with load and saturating decrement.
// Shared by the game_timer block; no configuration macros.
module bcd2_down_counter
  import air_hockey_pkg::*;
#(
  parameter logic [2*BCD_W-1:0] INIT = 8'h60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [2*BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             zero_next
);

  logic at_zero;

  assign at_zero = (tens == '0) && (ones == '0);
  assign zero_next = (tens == '0) && (ones == BCD_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= INIT[2*BCD_W-1:BCD_W];
      ones <= INIT[BCD_W-1:0];
    end else if (load) begin
      tens <= load_val[2*BCD_W-1:BCD_W];
      ones <= load_val[BCD_W-1:0];
    end else if (dec && !at_zero) begin
      if (ones == '0) begin
        ones <= BCD_W'(9);
        tens <= tens - BCD_W'(1);
      end else begin
        ones <= ones - BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_timer.sv
// Match countdown FSM with post-goal freeze and end-of-match flag.
// Define GAME_TIMER_WARN_EN to enable the low-time warn output.
module game_timer
  import air_hockey_pkg::*;
#(
  parameter int GAME_SECONDS = 60,
  parameter int PAUSE_SECONDS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timeclk,
  input  logic             start,
  input  logic             goal,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic             freeze,
  output logic             time_up,
  output logic             warn
);

  localparam logic [2*BCD_W-1:0] RELOAD =
    to_bcd(GAME_SECONDS);
  localparam logic [3:0] PAUSE_LD = 4'(PAUSE_SECONDS);

  state_t     state, state_n;
  logic [3:0] pcnt, pcnt_n;
  logic       load, dec, zero_next;

  bcd2_down_counter #(
    .INIT(RELOAD)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (RELOAD),
    .dec      (dec),
    .tens     (sec_tens),
    .ones     (sec_ones),
    .zero_next(zero_next)
  );

  always_comb begin
    state_n = state;
    pcnt_n = pcnt;
    load = 1'b0;
    dec = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n = RUN;
          load = 1'b1;
        end
      end
      RUN: begin
        if (timeclk) begin
          dec = 1'b1;
          if (zero_next) begin
            state_n = OVER;
          end else if (goal) begin
            state_n = PAUSE;
            pcnt_n = PAUSE_LD;
          end
        end else if (goal) begin
          state_n = PAUSE;
          pcnt_n = PAUSE_LD;
        end
      end
      PAUSE: begin
        if (goal) begin
          pcnt_n = PAUSE_LD;
        end else if (timeclk) begin
          pcnt_n = pcnt - 4'd1;
          if (pcnt == 4'd1) state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pcnt <= 4'd0;
      running <= 1'b0;
      freeze <= 1'b0;
      time_up <= 1'b0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      running <= (state_n == RUN);
      freeze <= (state_n == PAUSE);
      time_up <= (state_n == OVER);
    end
  end

`ifdef GAME_TIMER_WARN_EN
  localparam logic [2*BCD_W-1:0] WARN_BCD =
    to_bcd(WARN_SECONDS);
  localparam logic [2*BCD_W-1:0] WARN_BCD1 =
    to_bcd(WARN_SECONDS + 1);

  logic [2*BCD_W-1:0] cur;
  logic               warn_n;

  assign cur = {sec_tens, sec_ones};

  // Evaluate against the value the digits will hold after this edge.
  always_comb begin
    warn_n = 1'b0;
    if (state_n == RUN || state_n == PAUSE) begin
      if (load) warn_n = (RELOAD <= WARN_BCD);
      else if (dec) warn_n = (cur <= WARN_BCD1);
      else warn_n = (cur <= WARN_BCD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warn <= 1'b0;
    else warn <= warn_n;
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer (60 s and 12 s builds).
// Warn expectations follow GAME_TIMER_WARN_EN.
module tb_game_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeclk = 1'b0;
  logic start = 1'b0;
  logic goal = 1'b0;

  logic [3:0] t60, o60, t12, o12;
  logic r60, f60, u60, w60;
  logic r12, f12, u12, w12;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  game_timer #(.GAME_SECONDS(60), .PAUSE_SECONDS(3)) dut (
    .clk(clk), .rst_n(rst_n), .timeclk(timeclk),
    .start(start), .goal(goal),
    .sec_tens(t60), .sec_ones(o60),
    .running(r60), .freeze(f60),
    .time_up(u60), .warn(w60)
  );

  game_timer #(.GAME_SECONDS(12), .PAUSE_SECONDS(3)) dut12 (
    .clk(clk), .rst_n(rst_n), .timeclk(timeclk),
    .start(start), .goal(goal),
    .sec_tens(t12), .sec_ones(o12),
    .running(r12), .freeze(f12),
    .time_up(u12), .warn(w12)
  );

  function automatic logic wexp(input int r, input bit act);
`ifdef GAME_TIMER_WARN_EN
    return act && (r <= 10);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] vec(
    input int r, input bit run, input bit frz, input bit up
  );
    return {4'(r / 10), 4'(r % 10), run, frz, up,
            wexp(r, run | frz)};
  endfunction

  task automatic tick();
    @(negedge clk) timeclk = 1'b1;
    @(negedge clk) timeclk = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_goal(input bit with_tick);
    @(negedge clk) begin
      goal = 1'b1;
      timeclk = with_tick;
    end
    @(negedge clk) begin
      goal = 1'b0;
      timeclk = 1'b0;
    end
  endtask

  task automatic do_reset();
    timeclk = 1'b0;
    start = 1'b0;
    goal = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] e;
    do_reset();
    e = vec(60, 0, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL reset60 got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    e = vec(12, 0, 0, 0);
    total++;
    if ({t12, o12, r12, f12, u12, w12} !== e) begin
      bad++;
      $display("FAIL reset12 got=%h exp=%h",
        {t12, o12, r12, f12, u12, w12}, e);
    end
  endtask

  task automatic test_idle_ignore();
    logic [11:0] e;
    do_reset();
    tick();
    pulse_goal(1'b1);
    pulse_goal(1'b0);
    e = vec(60, 0, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL idle_ignore got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
  endtask

  task automatic test_countdown();
    logic [11:0] e;
    do_reset();
    pulse_start();
    e = vec(60, 1, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL start got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = vec(60 - i, 1, 0, 0);
      total++;
      if ({t60, o60, r60, f60, u60, w60} !== e) begin
        bad++;
        $display("FAIL count%0d got=%h exp=%h", i,
          {t60, o60, r60, f60, u60, w60}, e);
      end
    end
  endtask

  task automatic test_goal_pause();
    logic [11:0] e;
    do_reset();
    pulse_start();
    ticks(15);
    pulse_goal(1'b0);
    e = vec(45, 0, 1, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL goal_enter got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = vec(45, i == 3, i != 3, 0);
      total++;
      if ({t60, o60, r60, f60, u60, w60} !== e) begin
        bad++;
        $display("FAIL pause_tick%0d got=%h exp=%h", i,
          {t60, o60, r60, f60, u60, w60}, e);
      end
    end
    tick();
    e = vec(44, 1, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL resume got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
  endtask

  task automatic test_goal_tick_same();
    logic [11:0] e;
    ticks(24);
    e = vec(20, 1, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL at20 got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    pulse_goal(1'b1);
    e = vec(19, 0, 1, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL same_cycle got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    ticks(2);
    pulse_goal(1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = vec(19, i == 3, i != 3, 0);
      total++;
      if ({t60, o60, r60, f60, u60, w60} !== e) begin
        bad++;
        $display("FAIL regoal_tick%0d got=%h exp=%h", i,
          {t60, o60, r60, f60, u60, w60}, e);
      end
    end
    tick();
    e = vec(18, 1, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL regoal_resume got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
  endtask

  task automatic test_reset_mid_pause();
    logic [11:0] e;
    do_reset();
    pulse_start();
    ticks(27);
    pulse_goal(1'b0);
    e = vec(33, 0, 1, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL pause33 got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    #2 rst_n = 1'b0;
    #1;
    e = vec(60, 0, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL post_reset_idle got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
  endtask

  task automatic test_over_restart();
    logic [11:0] e;
    int r;
    do_reset();
    pulse_start();
    for (int i = 1; i <= 62; i++) begin
      tick();
      r = (60 - i > 0) ? 60 - i : 0;
      e = vec(r, r > 0, 0, r == 0);
      total++;
      if ({t60, o60, r60, f60, u60, w60} !== e) begin
        bad++;
        $display("FAIL run60_t%0d got=%h exp=%h", i,
          {t60, o60, r60, f60, u60, w60}, e);
      end
      r = (12 - i > 0) ? 12 - i : 0;
      e = vec(r, r > 0, 0, r == 0);
      total++;
      if ({t12, o12, r12, f12, u12, w12} !== e) begin
        bad++;
        $display("FAIL run12_t%0d got=%h exp=%h", i,
          {t12, o12, r12, f12, u12, w12}, e);
      end
    end
    pulse_goal(1'b1);
    pulse_start();
    e = vec(60, 1, 0, 0);
    total++;
    if ({t60, o60, r60, f60, u60, w60} !== e) begin
      bad++;
      $display("FAIL restart60 got=%h exp=%h",
        {t60, o60, r60, f60, u60, w60}, e);
    end
    e = vec(12, 1, 0, 0);
    total++;
    if ({t12, o12, r12, f12, u12, w12} !== e) begin
      bad++;
      $display("FAIL restart12 got=%h exp=%h",
        {t12, o12, r12, f12, u12, w12}, e);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_countdown();
    test_goal_pause();
    test_goal_tick_same();
    test_reset_mid_pause();
    test_over_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
